// File: rtl/ram_arbiter.sv
// Two-master round-robin arbiter in front of a 32x32 single-port RAM.
// Burst-limited grants, zero-bubble handover, one-cycle read-valid return.
module ram_arbiter #(
    parameter int unsigned MAX_BURST = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [4:0]  m0_addr,
    input  logic [31:0] m0_din,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [4:0]  m1_addr,
    input  logic [31:0] m1_din,
    output logic        m0_grant,
    output logic        m1_grant,
    output logic        m0_rvalid,
    output logic        m1_rvalid,
    output logic [31:0] m_dout,
    output logic        ram_cen,
    output logic        ram_wen,
    output logic [4:0]  ram_addr,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout
);

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            lg_q, lg_d;        // last granted master: 0 = m0, 1 = m1
    logic            rd_pend_q, rd_pend_d;
    logic            rd_id_q, rd_id_d;

    logic            sel_m1;
    logic            own_req;
    logic            own_wr;
    logic [AW-1:0]   own_addr;
    logic [DW-1:0]   own_din;
    logic            oth_req;
    logic            access;
    state_e          oth_state;

    // Select the owning master's bus and decide whether this is an access cycle.
    always_comb begin
        sel_m1    = (state_q == GNT1);
        own_req   = sel_m1 ? m1_req  : m0_req;
        own_wr    = sel_m1 ? m1_wr   : m0_wr;
        own_addr  = sel_m1 ? m1_addr : m0_addr;
        own_din   = sel_m1 ? m1_din  : m0_din;
        oth_req   = sel_m1 ? m0_req  : m1_req;
        oth_state = sel_m1 ? GNT0    : GNT1;
        access    = (state_q != IDLE) && own_req;
    end

    // RAM pins are quiet (all zero) outside access cycles.
    always_comb begin
        ram_cen  = access;
        ram_wen  = access && own_wr;
        ram_addr = access ? own_addr : '0;
        ram_din  = access ? own_din  : '0;
    end

    // Next-state, burst counter, round-robin pointer and read tracking.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lg_d      = lg_q;
        rd_pend_d = 1'b0;
        rd_id_d   = rd_id_q;

        if (access && !own_wr) begin
            rd_pend_d = 1'b1;
            rd_id_d   = sel_m1;
        end

        case (state_q)
            IDLE: begin
                if (m0_req && (!m1_req || lg_q)) begin
                    state_d = GNT0;
                end else if (m1_req) begin
                    state_d = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (!own_req) begin
                    state_d = oth_req ? oth_state : IDLE;
                end else if (oth_req && (cnt_q == BURST_LAST)) begin
                    state_d = oth_state;
                end else if (cnt_q != BURST_LAST) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
            if (state_d == GNT0) lg_d = 1'b0;
            if (state_d == GNT1) lg_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            lg_q      <= 1'b1;
            rd_pend_q <= 1'b0;
            rd_id_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lg_q      <= lg_d;
            rd_pend_q <= rd_pend_d;
            rd_id_q   <= rd_id_d;
        end
    end

    assign m0_grant  = (state_q == GNT0);
    assign m1_grant  = (state_q == GNT1);
    assign m0_rvalid = rd_pend_q && !rd_id_q;
    assign m1_rvalid = rd_pend_q &&  rd_id_q;
    assign m_dout    = ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 32x32 RAM attached.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [4:0]  m0_addr, m1_addr;
    logic [31:0] m0_din, m1_din;
    logic        m0_grant, m1_grant, m0_rvalid, m1_rvalid;
    logic [31:0] m_dout;
    logic        ram_cen, ram_wen;
    logic [4:0]  ram_addr;
    logic [31:0] ram_din, ram_dout;

    logic [31:0] mem [32];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.MAX_BURST(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_din(m0_din),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_din(m1_din),
        .m0_grant(m0_grant), .m1_grant(m1_grant),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid), .m_dout(m_dout),
        .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Single-port RAM: write at the edge, read data registered for the next cycle.
    always @(posedge clk) begin
        if (ram_cen) begin
            if (ram_wen) mem[ram_addr] <= ram_din;
            else         ram_dout      <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        m0_req = 0; m0_wr = 0; m0_addr = '0; m0_din = '0;
        m1_req = 0; m1_wr = 0; m1_addr = '0; m1_din = '0;
        #3;
        chk("rst_m0_grant", 32'(m0_grant), 0);
        chk("rst_m1_grant", 32'(m1_grant), 0);
        chk("rst_cen", 32'(ram_cen), 0);
        chk("rst_wen", 32'(ram_wen), 0);
        chk("rst_addr", 32'(ram_addr), 0);
        chk("rst_din", ram_din, 0);
        chk("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 0);
        cyc();
        reset_n = 1'b1;
        cyc();

        // Single master: m0 writes addr 1..31 with data = addr.
        m0_req = 1; m0_wr = 1; m0_addr = 5'd1; m0_din = 32'd1;
        settle();
        chk("w_idle_grant", 32'(m0_grant), 0);
        cyc();
        for (int a = 1; a < 32; a++) begin
            m0_addr = 5'(a); m0_din = 32'(a);
            settle();
            chk("w_grant", {30'd0, m1_grant, m0_grant}, 1);
            chk("w_cen_wen", {30'd0, ram_cen, ram_wen}, 3);
            chk("w_addr", 32'(ram_addr), 32'(a));
            chk("w_din", ram_din, 32'(a));
            chk("w_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 0);
            cyc();
        end
        // m0 reads them back; data returns one cycle after each read.
        m0_wr = 0;
        for (int a = 1; a < 32; a++) begin
            m0_addr = 5'(a);
            settle();
            chk("r_cen_wen", {30'd0, ram_cen, ram_wen}, 2);
            chk("r_addr", 32'(ram_addr), 32'(a));
            chk("r_m1", {30'd0, m1_grant, m1_rvalid}, 0);
            if (a == 1) begin
                chk("r_first_rvalid", 32'(m0_rvalid), 0);
            end else begin
                chk("r_rvalid", 32'(m0_rvalid), 1);
                chk("r_dout", m_dout, 32'(a - 1));
            end
            cyc();
        end
        m0_req = 0;
        settle();
        chk("r_last_rvalid", 32'(m0_rvalid), 1);
        chk("r_last_dout", m_dout, 32'd31);
        chk("r_last_cen", 32'(ram_cen), 0);
        cyc();
        chk("r_done_idle", {29'd0, m1_grant, m0_grant, m0_rvalid}, 0);

        // First tie after a fresh reset goes to m0, then zero-bubble handover to m1.
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        cyc();
        m0_req = 1; m0_wr = 1; m0_addr = 5'd0; m0_din = 32'hA;
        m1_req = 1; m1_wr = 1; m1_addr = 5'd0; m1_din = 32'hB;
        settle();
        chk("tie_idle", {30'd0, m1_grant, m0_grant}, 0);
        cyc();
        chk("tie_m0_first", {30'd0, m1_grant, m0_grant}, 1);
        chk("tie_m0_din", ram_din, 32'hA);
        cyc();
        m0_req = 0;
        settle();
        chk("tie_m0_drop_cen", 32'(ram_cen), 0);
        cyc();
        chk("tie_m1_next", {30'd0, m1_grant, m0_grant}, 2);
        chk("tie_m1_din", ram_din, 32'hB);
        m1_req = 0;
        cyc();
        chk("tie_idle_end", {30'd0, m1_grant, m0_grant}, 0);

        // Burst limit with both requesting; m0's 8th access reads addr 5.
        m0_req = 1; m1_req = 1;
        cyc();
        for (int i = 0; i < 8; i++) begin
            m0_wr   = (i < 7);
            m0_addr = (i < 7) ? 5'd0 : 5'd5;
            settle();
            chk("b_m0_grant", {30'd0, m1_grant, m0_grant}, 1);
            chk("b_m0_cen", 32'(ram_cen), 1);
            cyc();
        end
        m0_wr = 1; m0_addr = 5'd0;
        settle();
        chk("hand_m1_grant", {30'd0, m1_grant, m0_grant}, 2);
        chk("hand_m0_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 1);
        chk("hand_dout", m_dout, 32'd5);
        chk("hand_m1_access", {30'd0, ram_cen, ram_wen}, 3);
        cyc();
        for (int i = 1; i < 8; i++) begin
            chk("b_m1_grant", {30'd0, m1_grant, m0_grant}, 2);
            chk("b_m1_cen", 32'(ram_cen), 1);
            cyc();
        end
        for (int i = 0; i < 8; i++) begin
            chk("b_m0_again", {30'd0, m1_grant, m0_grant}, 1);
            chk("b_m0_again_cen", 32'(ram_cen), 1);
            cyc();
        end
        chk("b_m1_again", {30'd0, m1_grant, m0_grant}, 2);
        m0_req = 0; m1_req = 0;
        cyc();
        chk("b_idle", {30'd0, m1_grant, m0_grant}, 0);

        // Saturated counter: m1 alone for 20 accesses, then m0 requests.
        m1_req = 1; m1_wr = 1; m1_addr = 5'd0;
        cyc();
        for (int i = 0; i < 20; i++) begin
            chk("sat_m1_grant", {30'd0, m1_grant, m0_grant}, 2);
            chk("sat_cen", 32'(ram_cen), 1);
            cyc();
        end
        m0_req = 1; m0_wr = 1; m0_addr = 5'd0;
        settle();
        chk("sat_m1_last", {30'd0, m1_grant, m0_grant}, 2);
        chk("sat_m1_last_cen", 32'(ram_cen), 1);
        cyc();
        chk("sat_handover", {30'd0, m1_grant, m0_grant}, 1);

        // Asynchronous reset in the middle of an m1 read burst.
        m0_req = 0;
        m1_wr = 0; m1_addr = 5'd5;
        cyc();
        chk("ar_m1_grant", {30'd0, m1_grant, m0_grant}, 2);
        cyc();
        chk("ar_m1_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 2);
        chk("ar_dout", m_dout, 32'd5);
        reset_n = 1'b0;
        #1;
        chk("ar_grant_drop", {30'd0, m1_grant, m0_grant}, 0);
        chk("ar_cen_drop", {30'd0, ram_cen, ram_wen}, 0);
        chk("ar_rvalid_drop", {30'd0, m1_rvalid, m0_rvalid}, 0);
        chk("ar_addr_drop", 32'(ram_addr), 0);
        m0_req = 1; m0_wr = 1; m0_addr = 5'd0;
        #1;
        reset_n = 1'b1;
        cyc();
        chk("ar_m0_first", {30'd0, m1_grant, m0_grant}, 1);
        chk("ar_no_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 0);
        m0_req = 0; m1_req = 0;
        cyc();
        cyc();
        chk("end_idle", {30'd0, m1_grant, m0_grant}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
